// File: rtl/reg_writeback_queue.sv
// In-order write-back queue feeding one write port of the 8x16 register file.
// Requests are queued, then presented one per cycle on cs/cw/cd. The head
// entry is held while the register file signals wait. Pending-write flags
// let issue logic stall reads of registers that still have queued writes.
module reg_writeback_queue #(
  parameter  int DEPTH = 4,
  parameter  int DW    = 16,
  parameter  int AW    = 3,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_sel,
  input  logic [DW-1:0] in_data,
  output logic [AW-1:0] cs,
  output logic          cw,
  output logic [DW-1:0] cd,
  input  logic          wt,
  input  logic [AW-1:0] qa_sel,
  input  logic [AW-1:0] qb_sel,
  output logic          qa_busy,
  output logic          qb_busy,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic [7:0]    stall_cnt
);

  logic [DEPTH-1:0][AW-1:0] sel_q, sel_d;
  logic [DEPTH-1:0][DW-1:0] data_q, data_d;
  logic [DEPTH-1:0]         vld_q, vld_d;
  logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;
  logic [7:0]               stall_q, stall_d;
  logic                     push, pop;

  // Status and port drive come straight from registered state; no bypass.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    in_ready  = !full;
    count     = count_q;
    stall_cnt = stall_q;
    cw        = !empty;
    cs        = empty ? '0 : sel_q[head_q];
    cd        = empty ? '0 : data_q[head_q];
    push      = in_valid && in_ready;
    pop       = cw && !wt;
  end

  // Hazard flags: any valid entry (head included) targeting the read select.
  always_comb begin
    qa_busy = 1'b0;
    qb_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (sel_q[i] == qa_sel)) qa_busy = 1'b1;
      if (vld_q[i] && (sel_q[i] == qb_sel)) qb_busy = 1'b1;
    end
  end

  // Next-state: push at tail, retire at head, saturating stall counter.
  // Push needs !full and pop needs !empty, so they never hit the same slot.
  always_comb begin
    sel_d   = sel_q;
    data_d  = data_q;
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    stall_d = stall_q;
    if (push) begin
      sel_d[tail_q]  = in_sel;
      data_d[tail_q] = in_data;
      vld_d[tail_q]  = 1'b1;
      tail_d         = tail_q + 1'b1;
    end
    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (cw && wt && (stall_q != 8'hFF)) stall_d = stall_q + 1'b1;
  end

  // State register; reset discards all queued writes immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= '0;
      data_q  <= '0;
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= '0;
    end else begin
      sel_q   <= sel_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
    end
  end

endmodule
